// File: rtl/apu_decimate_filter_pkg.sv
// Shared constants, FSM encoding and coefficient ROM for the 8:1 decimating FIR.
// The 33 taps are symmetric and sum to exactly 1024 (unity DC gain after the >>>10).
package apu_decimate_filter_pkg;

    localparam int APU_DECIM_NTAPS  = 33;
    localparam int APU_DECIM_RATIO  = 8;
    localparam int APU_DECIM_COEF_W = 10;
    localparam int APU_DECIM_RND_C  = 512;
    localparam int APU_DECIM_RND_SH = 10;
    localparam int BUF_DEPTH        = 64;
    localparam int PTR_W            = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_ROUND = 2'd2
    } state_t;

    // Only the first half is stored; taps 17..32 mirror 15..0.
    function automatic logic signed [APU_DECIM_COEF_W-1:0] coef(input logic [5:0] k);
        logic [5:0] m;
        m = (k > 6'd16) ? 6'd32 - k : k;
        case (m)
            6'd0:    coef =  10'sd0;
            6'd1:    coef = -10'sd1;
            6'd2:    coef = -10'sd2;
            6'd3:    coef = -10'sd3;
            6'd4:    coef = -10'sd3;
            6'd5:    coef = -10'sd2;
            6'd6:    coef =  10'sd0;
            6'd7:    coef =  10'sd4;
            6'd8:    coef =  10'sd10;
            6'd9:    coef =  10'sd18;
            6'd10:   coef =  10'sd28;
            6'd11:   coef =  10'sd40;
            6'd12:   coef =  10'sd53;
            6'd13:   coef =  10'sd66;
            6'd14:   coef =  10'sd77;
            6'd15:   coef =  10'sd86;
            6'd16:   coef =  10'sd282;
            default: coef =  10'sd0;
        endcase
    endfunction

endpackage

// File: rtl/apu_decimate_filter_mac.sv
// Time-multiplexed tap MAC: coefficient ROM, 16x10 multiply, 32-bit accumulator, rounding.
// Optional output clamp selected by APU_DECIMATE_SATURATE_EN.
module apu_decimate_mac
    import apu_decimate_filter_pkg::*;
#(
    parameter int COEF_W = APU_DECIM_COEF_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        acc_en,
    input  logic [5:0]  tap,
    input  logic [15:0] sample,
    output logic [15:0] q_rnd
);

    logic signed [COEF_W-1:0] c;
    logic signed [15+COEF_W:0] prod;
    logic signed [31:0]        acc;
    logic signed [31:0]        rsum;

    assign c    = coef(tap);
    assign prod = $signed(sample) * c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + 32'(prod);
        end
    end

    assign rsum = acc + 32'(APU_DECIM_RND_C);

`ifdef APU_DECIMATE_SATURATE_EN
    logic signed [31:0] r;
    assign r = rsum >>> APU_DECIM_RND_SH;

    always_comb begin
        q_rnd = r[15:0];
        if (r > 32'sd32767)
            q_rnd = 16'h7fff;
        else if (r < -32'sd32768)
            q_rnd = 16'h8000;
    end
`else
    // Plain truncation: out-of-range results wrap.
    assign q_rnd = 16'(rsum >>> APU_DECIM_RND_SH);
`endif

endmodule

// File: rtl/apu_decimate_filter.sv
// 33-tap anti-alias FIR with 8:1 decimation over a 64-entry sample ring.
// Build option: APU_DECIMATE_SATURATE_EN clamps the output instead of wrapping.
module apu_decimate_filter
    import apu_decimate_filter_pkg::*;
#(
    parameter int NTAPS  = APU_DECIM_NTAPS,
    parameter int DECIM  = APU_DECIM_RATIO,
    parameter int COEF_W = APU_DECIM_COEF_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q,
    output logic        q_vld,
    output logic        ovr
);

    logic [15:0]      ring [BUF_DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] base;
    logic [PTR_W-1:0] rd_idx;
    logic [2:0]       phase;
    logic [5:0]       fill;
    logic [5:0]       tap;
    logic [15:0]      sample;
    logic [15:0]      q_rnd;
    logic             gc;
    logic             fill_ok;
    logic             start;
    logic             acc_clr;
    logic             acc_en;
    logic             rnd;
    state_t           state;
    state_t           state_nx;

    assign gc      = en && (phase == 3'(DECIM-1));
    assign fill_ok = (fill == 6'(NTAPS));
    assign start   = gc && fill_ok;

    // Taps walk backwards from the newest sample; later writes land past base.
    assign rd_idx  = base - 6'd1 - tap;
    assign sample  = ring[rd_idx];

    always_ff @(posedge clk) begin
        if (en)
            ring[wp] <= d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_MAC;
            S_MAC:   if (tap == 6'(NTAPS-1)) state_nx = S_ROUND;
            S_ROUND: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        rnd     = 1'b0;
        case (state)
            S_IDLE:  acc_clr = start;
            S_MAC:   acc_en  = 1'b1;
            S_ROUND: rnd     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp    <= '0;
            base  <= '0;
            phase <= '0;
            fill  <= '0;
            tap   <= '0;
            q     <= '0;
            q_vld <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            if (en) begin
                wp    <= wp + 6'd1;
                phase <= (phase == 3'(DECIM-1)) ? 3'd0 : phase + 3'd1;
                if (!fill_ok)
                    fill <= fill + 6'd1;
            end
            if (state == S_IDLE && start)
                base <= wp + 6'd1;
            tap   <= (state == S_MAC) ? tap + 6'd1 : 6'd0;
            q_vld <= rnd;
            if (rnd)
                q <= q_rnd;
            // A group landing while busy is dropped; the running MAC is untouched.
            if (gc && state != S_IDLE)
                ovr <= 1'b1;
        end
    end

    apu_decimate_mac #(
        .COEF_W (COEF_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .acc_en (acc_en),
        .tap    (tap),
        .sample (sample),
        .q_rnd  (q_rnd)
    );

endmodule

// File: tb/tb_apu_decimate_filter.sv
// Directed bench for apu_decimate_filter: DC, latency, impulse, saturation, overrun, mid-MAC reset.
module tb_apu_decimate_filter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] d;
    logic [15:0] q;
    logic        q_vld;
    logic        ovr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference taps, written out independently of the package.
    int C [33] = '{0, -1, -2, -3, -3, -2, 0, 4, 10, 18, 28, 40, 53, 66, 77, 86, 282,
                   86, 77, 66, 53, 40, 28, 18, 10, 4, 0, -2, -3, -3, -2, -1, 0};

    apu_decimate_filter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (d),
        .q     (q),
        .q_vld (q_vld),
        .ovr   (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, input int gap);
        d  = 16'(v);
        en = 1'b1;
        tick();
        en = 1'b0;
        repeat (gap - 1) tick();
    endtask

    // Reference model and output monitor
    int hist [$];
    int exp_v [$];
    int exp_t [$];
    int cyc      = 0;
    int m_phase  = 0;
    int m_fill   = 0;
    int busy_end = 0;
    int n_out    = 0;
    int q_sum    = 0;
    int last_q   = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_phase  = 0;
            m_fill   = 0;
            busy_end = 0;
            exp_v.delete();
            exp_t.delete();
        end else begin
            if (q_vld) begin
                n_out++;
                q_sum += int'($signed(q));
                last_q = int'(q);
                if (exp_v.size() == 0) begin
                    chk("unexpected_q_vld", 1, 0);
                end else begin
                    chk("q_model", q, exp_v.pop_front());
                    chk("latency", cyc - exp_t.pop_front(), 35);
                end
            end
            if (en) begin
                hist.push_back(int'($signed(d)));
                if (m_phase == 7 && m_fill == 33 && cyc >= busy_end) begin
                    longint acc;
                    longint r;
                    int n;
                    acc = 0;
                    n = hist.size() - 1;
                    for (int k = 0; k < 33; k++)
                        acc += longint'(C[k]) * longint'(hist[n-k]);
                    r = (acc + 512) >>> 10;
`ifdef APU_DECIMATE_SATURATE_EN
                    if (r > 32767)  r = 32767;
                    if (r < -32768) r = -32768;
`endif
                    exp_v.push_back(int'(r[15:0]));
                    exp_t.push_back(cyc);
                    busy_end = cyc + 35;
                end
                m_phase = (m_phase + 1) % 8;
                if (m_fill < 33) m_fill++;
            end
        end
    end

    initial begin
        int o0;
        int s0;
        rst_n = 1'b0;
        en    = 1'b0;
        d     = '0;
        repeat (3) tick();
        chk("rst_q", q, 0);
        chk("rst_q_vld", q_vld, 0);
        chk("rst_ovr", ovr, 0);
        rst_n = 1'b1;
        tick();

        // DC: nothing before the 40th en, then unity gain
        o0 = n_out;
        repeat (39) send(1000, 5);
        repeat (40) tick();
        chk("dc_no_early_out", n_out - o0, 0);
        repeat (9) send(1000, 5);
        repeat (40) tick();
        chk("dc_nout", n_out - o0, 2);
        chk("dc_q", last_q, 1000);
        chk("dc_hold_q", q, 1000);
        chk("dc_hold_vld", q_vld, 0);
        chk("dc_ovr", ovr, 0);

        // Impulse at all 8 phase alignments
        repeat (40) send(0, 5);
        repeat (40) tick();
        o0 = n_out;
        s0 = q_sum;
        for (int j = 0; j < 8; j++) begin
            repeat (j) send(0, 5);
            send(1024, 5);
            repeat (47 - j) send(0, 5);
        end
        repeat (40) tick();
        chk("imp_nout", n_out - o0, 48);
        chk("imp_sum", q_sum - s0, 1024);

        // Sign-matched full-scale window: r = +34175 / -34176 before clamp
        repeat (7) send(32767, 5);
        for (int k = 32; k >= 0; k--) send((C[k] < 0) ? -32768 : 32767, 5);
        repeat (40) tick();
`ifdef APU_DECIMATE_SATURATE_EN
        chk("sat_pos", last_q, 32'h7fff);
`else
        chk("wrap_pos", last_q, 32'h857f);
`endif
        repeat (7) send(-32768, 5);
        for (int k = 32; k >= 0; k--) send((C[k] < 0) ? 32767 : -32768, 5);
        repeat (40) tick();
`ifdef APU_DECIMATE_SATURATE_EN
        chk("sat_neg", last_q, 32'h8000);
`else
        chk("wrap_neg", last_q, 32'h7a80);
`endif

        // Overrun: en every 2 clocks, groups 2 and 3 land during the MAC
        chk("ovr_pre", ovr, 0);
        o0 = n_out;
        for (int i = 0; i < 24; i++) send(i * 37 - 300, 2);
        repeat (40) tick();
        chk("ovr_set", ovr, 1);
        chk("ovr_nout", n_out - o0, 1);

        // Reset about 10 clocks into a MAC
        o0 = n_out;
        repeat (7) send(500, 5);
        send(500, 1);
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_q", q, 0);
        chk("mrst_ovr", ovr, 0);
        repeat (39) send(700, 5);
        repeat (40) tick();
        chk("mrst_no_out", n_out - o0, 0);
        send(700, 5);
        repeat (40) tick();
        chk("mrst_nout", n_out - o0, 1);
        chk("mrst_q_after", last_q, 700);
        chk("mrst_ovr_end", ovr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apu_decimate_filter.md
Name: apu_decimate_filter

Overview:
Anti-alias lowpass FIR plus 8:1 decimator for the APU, taking 8 * 48 kSa/s samples down to 48 kSa/s. It is the return path for the upsampling interpolation filter, used to bring oversampled audio back to the mixer sample rate.
Each group of 8 input samples produces one output. A single time-multiplexed multiply-accumulate evaluates all 33 taps sequentially over a sample ring buffer.

Parameters:
NTAPS, 33, FIR length; fixed by the coefficient header, not to be overridden
DECIM, 8, decimation ratio; one output per DECIM accepted inputs
COEF_W, 10, signed coefficient width; DC gain normalised to 2^COEF_W

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-low
en  input  1  input strobe; d is sampled on cycles where en=1
d  input  16  signed two's-complement input sample
q  output  16  signed decimated output sample; held between updates
q_vld  output  1  one-cycle pulse when q updates
ovr  output  1  sticky overrun flag

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (sync, any state, including mid-MAC):
  - FSM goes to IDLE; phase counter and fill counter are cleared.
  - q=0, q_vld=0, ovr=0; accumulator cleared.
  - Ring buffer contents are not reset.
- Ring buffer:
  - 64 x 16 registers; 6-bit write pointer wp increments on every en and wraps 63->0.
  - Each en writes d at wp regardless of FSM state.
- Phase counter, 3 bits: increments on en. The en that takes it 7->0 is the group-complete event.
- Fill counter: saturates at 33. While it is below 33, group-complete events are ignored and produce no output.
- FSM states: IDLE, MAC, ROUND.
  - IDLE->MAC on a group-complete event with fill=33. Latch base = wp after the write, i.e. pointing one past the newest sample.
  - MAC runs 33 cycles, tap k=0..32. Each cycle reads buffer[base-1-k] (mod 64) and accumulates coef[k]*sample.
  - The accumulator is 32-bit signed; no intermediate overflow is possible.
  - MAC->ROUND after k=32, then ROUND->IDLE.
  - In ROUND: r = (acc + 512) >>> 10, arithmetic. Assign q = r[15:0] (see optional feature). Pulse q_vld.
- Latency: if group-complete en is at cycle T, q_vld is high in cycle T+35 exactly.
- Input rate: en must be spaced at least 5 clocks apart. A group then spans at least 36 clocks, so the MAC always finishes before the next group.
  - Up to 7 newer samples written during MAC do not disturb the taps being read, because the buffer depth is 64, greater than 33+7.
- Overrun: a group-complete event while FSM != IDLE sets ovr (sticky until reset).
  - That group is dropped; the in-progress MAC continues unaffected.
- en at cycle T+35 coincident with q_vld is legal; both take effect.

Optional Feature:
APU_DECIMATE_SATURATE_EN:
- Defined: in ROUND, r is clamped to [-32768, 32767] before output.
- Undefined: q = r[15:0], which wraps on overflow; this saves a comparator.

Decomposition:
- Shared header apu_decimate_coeffs.vh holds:
  - APU_DECIM_NTAPS, APU_DECIM_RATIO;
  - the 33 signed 10-bit coefficients as localparams: symmetric, c[k]=c[32-k], sum exactly 1024;
  - the rounding constant 512 and shift 10.
- One sub-module, apu_decimate_mac: coefficient ROM mux, 16x10 signed multiply, 32-bit accumulate/clear, round and optional saturate.
- The top level keeps the ring buffer, counters, FSM and ovr.

Test Plan:
1. DC d=1000 with en every 5 clocks: first q_vld follows the 40th en (33 fill, then group completion); q=1000 on every output; ovr=0.
2. Latency: after fill, measure from the group-complete en to q_vld; it must be exactly 35 clocks. q_vld is one cycle wide, and q is held between pulses.
3. Impulse: d=1024 at one sample, all others 0. The successive outputs equal the package coefficients at the decimated tap positions, bit-exact against a reference model. The sum over all 8 phase alignments is 1024.
4. Overrun: en every 2 clocks. The second group-complete during MAC sets ovr=1, that output is missing, and the in-flight q is still correct.
5. Saturation: alternating +32767/-32768 square wave at the decimated rate edge. With APU_DECIMATE_SATURATE_EN, q stays within range and clips at 32767 or -32768. Without it, q matches the wrapped r[15:0] from the model.
6. Mid-MAC reset: assert rst_n=0 for one clock at T+10. q=0, q_vld never pulses, ovr=0, and 33 new samples are needed before the next output.
